// File: rtl/mem_pkg.sv
// Shared types and helpers for the line-granular main-memory model.
// Provides the FSM state type, default geometry and the width helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mem_state_e;

  localparam int unsigned DEF_LINE_W = 256;
  localparam int unsigned DEF_DEPTH  = 512;

  // Bit width needed to index n items; never below one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_line_array.sv
// Single-port line store with write enable and a registered read port.
// The storage array is left unreset so a bench can preload it through `memory`.
module mem_line_array #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned IDX_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              rd,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] memory [0:DEPTH-1];
  logic [LINE_W-1:0] rdata_r;

  // Line write
  always_ff @(posedge clk) begin
    if (we) begin
      memory[idx] <= wdata;
    end
  end

  // Read register: cleared by reset, otherwise holds the last line read
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {LINE_W{1'b0}};
    end else if (rd) begin
      rdata_r <= memory[idx];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/line_memory.sv
// Line-granular main-memory model with fixed access latency, enable/ack
// handshake, busy flag and saturating read/write access counters.
module line_memory
  import mem_pkg::*;
#(
  parameter int unsigned LINE_W  = DEF_LINE_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LATENCY = 10,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  rd_count_o,
  output logic [CNT_W-1:0]  wr_count_o
);

  localparam int unsigned OFF_W = width_of(LINE_W / 32'd8);
  localparam int unsigned IDX_W = width_of(DEPTH);
  localparam int unsigned CD_W  = width_of(LATENCY);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'((LATENCY > 32'd1) ? LATENCY - 32'd2 : 32'd0);

  mem_state_e        state_r, state_nx_s;
  logic [CD_W-1:0]   cnt_r, cnt_nx_s;
  logic [IDX_W-1:0]  idx_r;
  logic              wr_r;
  logic [LINE_W-1:0] wdata_r;
  logic              ack_r, busy_r;
  logic [CNT_W-1:0]  rd_count_r, wr_count_r;

  logic [IDX_W-1:0]  addr_idx_s, arr_idx_s;
  logic              accept_s, req_wr_s, arr_rd_s, arr_we_s;
  logic              unused_addr_s;

  assign addr_idx_s    = addr_i[OFF_W+IDX_W-1:OFF_W];
  assign unused_addr_s = ^addr_i;
  assign accept_s      = (state_r == IDLE) && enable_i;

  // Next-state and countdown logic
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (enable_i) begin
          if (LATENCY == 32'd1) begin
            state_nx_s = ACK;
          end else begin
            state_nx_s = WAIT;
            cnt_nx_s   = CD_LOAD;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == {CD_W{1'b0}}) begin
          state_nx_s = ACK;
        end else begin
          cnt_nx_s = cnt_r - CD_W'(1);
        end
      end
      ACK:     state_nx_s = IDLE;
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {CD_W{1'b0}};
      end
    endcase
  end

  // FSM state, countdown and registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= {CD_W{1'b0}};
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      ack_r   <= (state_nx_s == ACK);
      busy_r  <= (state_nx_s != IDLE);
    end
  end

  // Request capture on the accept edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_r   <= {IDX_W{1'b0}};
      wr_r    <= 1'b0;
      wdata_r <= {LINE_W{1'b0}};
    end else if (accept_s) begin
      idx_r   <= addr_idx_s;
      wr_r    <= write_i;
      wdata_r <= data_i;
    end
  end

  // Saturating access counters, bumped as the ACK cycle ends
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_count_r <= {CNT_W{1'b0}};
      wr_count_r <= {CNT_W{1'b0}};
    end else if (state_r == ACK) begin
      if (wr_r) begin
        if (wr_count_r != {CNT_W{1'b1}}) wr_count_r <= wr_count_r + CNT_W'(1);
      end else begin
        if (rd_count_r != {CNT_W{1'b1}}) rd_count_r <= rd_count_r + CNT_W'(1);
      end
    end
  end

  // The read is issued on the edge entering ACK so data is ready during ACK;
  // with LATENCY=1 that edge is the accept edge, hence the direct address path.
  assign req_wr_s  = (state_r == IDLE) ? write_i : wr_r;
  assign arr_idx_s = (state_r == IDLE) ? addr_idx_s : idx_r;
  assign arr_rd_s  = !rst_i && (state_nx_s == ACK) && (state_r != ACK) && !req_wr_s;
  assign arr_we_s  = !rst_i && (state_r == ACK) && wr_r;

  mem_line_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_line_array (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (arr_we_s),
    .rd    (arr_rd_s),
    .idx   (arr_idx_s),
    .wdata (wdata_r),
    .rdata (data_o)
  );

  assign ack_o      = ack_r;
  assign busy_o     = busy_r;
  assign rd_count_o = rd_count_r;
  assign wr_count_o = wr_count_r;

endmodule

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory: a LATENCY=10 instance and a LATENCY=1
// instance with 2-bit counters, driven from a vector table plus corner sequences.
module tb_line_memory;

  localparam logic [255:0] P0   = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [255:0] P1   = {8{32'hC0DE_0001}};
  localparam logic [255:0] P511 = {8{32'h1FF0_BEEF}};
  localparam logic [255:0] A5   = {32{8'hA5}};
  localparam logic [255:0] XV   = {16{16'h5A3C}};
  localparam logic [255:0] DV   = {8{32'h0DDC_0FFE}};
  localparam logic [255:0] ZV   = {32{8'h33}};
  localparam logic [255:0] PB2  = {8{32'hB2B2_0002}};
  localparam logic [255:0] PB3  = {8{32'hB3B3_0003}};

  typedef struct {
    bit           sel;
    bit           w;
    logic [31:0]  a;
    logic [255:0] d;
    logic [255:0] exp_d;
    int           rd;
    int           wr;
  } vec_t;

  typedef struct {
    logic [255:0] data;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_en, a_wr, a_ack, a_busy;
  logic [31:0]  a_addr, a_rdc, a_wrc;
  logic [255:0] a_din, a_dout;
  logic         b_en, b_wr, b_ack, b_busy;
  logic [31:0]  b_addr;
  logic [1:0]   b_rdc, b_wrc;
  logic [255:0] b_din, b_dout;

  line_memory #(.LATENCY(10)) u_a (
    .clk_i(clk), .rst_i(rst), .enable_i(a_en), .write_i(a_wr), .addr_i(a_addr),
    .data_i(a_din), .ack_o(a_ack), .data_o(a_dout), .busy_o(a_busy),
    .rd_count_o(a_rdc), .wr_count_o(a_wrc)
  );

  line_memory #(.LATENCY(1), .CNT_W(2)) u_b (
    .clk_i(clk), .rst_i(rst), .enable_i(b_en), .write_i(b_wr), .addr_i(b_addr),
    .data_i(b_din), .ack_o(b_ack), .data_o(b_dout), .busy_o(b_busy),
    .rd_count_o(b_rdc), .wr_count_o(b_wrc)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  bit   cur_sel = 1'b0;
  exp_t sb[$];
  vec_t vecs[9];

  logic         ack_s, busy_s;
  logic [255:0] data_s;
  logic [31:0]  rd_s, wr_s;

  always_comb begin
    ack_s  = cur_sel ? b_ack  : a_ack;
    busy_s = cur_sel ? b_busy : a_busy;
    data_s = cur_sel ? b_dout : a_dout;
    rd_s   = cur_sel ? {30'd0, b_rdc} : a_rdc;
    wr_s   = cur_sel ? {30'd0, b_wrc} : a_wrc;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic set_en(input bit sel, input logic v);
    if (sel) b_en = v;
    else     a_en = v;
  endtask

  // One complete request: drive, push expectation, wait (bounded) for ack, compare.
  task automatic run_req(input bit sel, input bit w, input logic [31:0] a, input logic [255:0] d,
                         input logic [255:0] exp_d, input int exp_rd, input int exp_wr, input int drop_at);
    exp_t e;
    int   cyc;
    int   busy_n;
    bit   got;
    cur_sel = sel;
    @(negedge clk);
    if (sel) begin b_en = 1'b1; b_wr = w; b_addr = a; b_din = d; end
    else     begin a_en = 1'b1; a_wr = w; a_addr = a; a_din = d; end
    e.data = exp_d;
    e.lat  = sel ? 1 : 10;
    sb.push_back(e);
    cyc = 0; busy_n = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy_s) busy_n++;
      if (cyc == drop_at) set_en(sel, 1'b0);
      if (ack_s) got = 1'b1;
    end
    set_en(sel, 1'b0);
    check("ack_seen", {255'd0, got}, 256'd1);
    e = sb.pop_front();
    if (got) begin
      check("ack_latency", 256'(cyc), 256'(e.lat));
      check("busy_cycles", 256'(busy_n), 256'(e.lat));
      check("data_o", data_s, e.data);
    end
    @(negedge clk);
    check("ack_one_cycle", {255'd0, ack_s}, 256'd0);
    check("busy_idle", {255'd0, busy_s}, 256'd0);
    check("rd_count", {224'd0, rd_s}, 256'(exp_rd));
    check("wr_count", {224'd0, wr_s}, 256'(exp_wr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    rst = 1'b1;
    a_en = 1'b1; a_wr = 1'b0; a_addr = 32'h0; a_din = 256'd0;
    b_en = 1'b0; b_wr = 1'b0; b_addr = 32'h0; b_din = 256'd0;
    u_a.u_line_array.memory[0]   = P0;
    u_a.u_line_array.memory[1]   = P1;
    u_a.u_line_array.memory[511] = P511;
    u_a.u_line_array.memory[17]  = 256'd0;
    u_b.u_line_array.memory[2]   = PB2;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 256'd0, P0,   1, 0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0220, A5,     P0,   1, 1};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0220, 256'd0, A5,   2, 1};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_4020, 256'd0, P1,   3, 1};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_3FFF, 256'd0, P511, 4, 1};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0040, XV,     P511, 4, 2};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0047, 256'd0, XV,   5, 2};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0040, 256'd0, PB2,  1, 0};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_0060, PB3,    PB2,  1, 1};

    // Reset held with enable high must not accept a request
    repeat (3) @(negedge clk);
    rst = 1'b0; a_en = 1'b0;
    check("rst_busy", {255'd0, a_busy}, 256'd0);
    check("rst_ack", {255'd0, a_ack}, 256'd0);
    check("rst_data", a_dout, 256'd0);
    check("rst_rd_count", {224'd0, a_rdc}, 256'd0);
    check("rst_wr_count", {224'd0, a_wrc}, 256'd0);

    for (int i = 0; i < 7; i++)
      run_req(vecs[i].sel, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_d, vecs[i].rd, vecs[i].wr, 0);
    check("line17", u_a.u_line_array.memory[17], A5);

    // Enable dropped mid-wait: write still completes
    run_req(1'b0, 1'b1, 32'h0000_0060, DV, XV, 5, 3, 2);
    run_req(1'b0, 1'b0, 32'h0000_0060, 256'd0, DV, 6, 3, 0);

    // Reset in cycle 5 of a write aborts it
    cur_sel = 1'b0;
    @(negedge clk);
    a_en = 1'b1; a_wr = 1'b1; a_addr = 32'h0000_0220; a_din = ZV;
    acks = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (a_ack) acks++;
      if (c == 5) begin rst = 1'b1; a_en = 1'b0; end
      if (c == 6) begin
        rst = 1'b0;
        check("abort_busy", {255'd0, a_busy}, 256'd0);
      end
    end
    check("abort_no_ack", 256'(acks), 256'd0);
    check("abort_line17", u_a.u_line_array.memory[17], A5);
    check("abort_rd_count", {224'd0, a_rdc}, 256'd0);
    check("abort_wr_count", {224'd0, a_wrc}, 256'd0);
    check("abort_data", a_dout, 256'd0);
    run_req(1'b0, 1'b0, 32'h0000_0220, 256'd0, A5, 1, 0, 0);

    // LATENCY=1 instance
    for (int i = 7; i < 9; i++)
      run_req(vecs[i].sel, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_d, vecs[i].rd, vecs[i].wr, 0);

    // Back-to-back reads at the minimum two-cycle spacing
    cur_sel = 1'b1;
    @(negedge clk);
    b_en = 1'b1; b_wr = 1'b0; b_addr = 32'h0000_0060;
    @(negedge clk);
    check("b2b_ack1", {255'd0, b_ack}, 256'd1);
    check("b2b_data1", b_dout, PB3);
    b_addr = 32'h0000_0040;
    @(negedge clk);
    check("b2b_gap_ack", {255'd0, b_ack}, 256'd0);
    check("b2b_gap_busy", {255'd0, b_busy}, 256'd0);
    @(negedge clk);
    check("b2b_ack2", {255'd0, b_ack}, 256'd1);
    check("b2b_data2", b_dout, PB2);
    b_en = 1'b0;
    @(negedge clk);
    check("b2b_rd_count", {254'd0, b_rdc}, 256'd3);

    // Counter already all-ones stays there
    run_req(1'b1, 1'b0, 32'h0000_0060, 256'd0, PB3, 3, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/line_memory.md
# line_memory

Parametrised, line-granular main-memory model with a fixed, configurable access latency and an enable/ack handshake. It sits behind the data cache, which drives the memory-request port. It is the successor to the fixed 16 KB, 256-bit, 512-line data memory: line width, depth, address width and latency are all parameters. It adds a busy indication and read/write access counters that the cache-statistics dump reads.

## Interface
- LINE_W, 256: line width in bits; a power of two, at least 32.
- DEPTH, 512: number of lines; a power of two.
- ADDR_W, 32: byte-address width.
- LATENCY, 10: cycles from request accept to ack; must be at least 1.
- CNT_W, 32: width of the access counters.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- enable_i  in  1  request valid.
- write_i  in  1  1 = line write, 0 = line read; sampled with enable_i.
- addr_i  in  ADDR_W  byte address of the line.
- data_i  in  LINE_W  write data.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  LINE_W  read data; valid while ack_o = 1 and held until the next read ack.
- busy_o  out  1  a request is in flight; enable_i is ignored while busy_o = 1.
- rd_count_o  out  CNT_W  completed reads; saturating.
- wr_count_o  out  CNT_W  completed writes; saturating.

## Operation
- Derived widths:
  - OFF_W = log2(LINE_W/8).
  - IDX_W = log2(DEPTH).
  - Line index = addr_i[OFF_W+IDX_W-1:OFF_W].
  - Address bits above the index are ignored, so addresses wrap modulo DEPTH lines.
  - Offset bits are ignored.
- State machine states: IDLE, WAIT, ACK.
- IDLE:
  - If enable_i = 1, latch the index, write_i and data_i (the accept edge).
  - Go to WAIT with the countdown loaded to LATENCY-2.
  - If LATENCY = 1, go directly to ACK.
- WAIT:
  - Decrement the countdown.
  - When it reaches 0, go to ACK on the next edge.
  - enable_i, addr_i and data_i are not observed; dropping enable_i mid-wait does not cancel the request.
- ACK:
  - ack_o = 1 for exactly one cycle.
  - Read: data_o = mem[latched index]; increment rd_count_o.
  - Write: mem[latched index] <= latched data on the edge that leaves ACK; increment wr_count_o; data_o is unchanged.
  - Go to IDLE.
- busy_o = 1 in WAIT and ACK, 0 in IDLE.
- Counters stop at all-ones; there is no wrap.
- Storage has no reset. Contents are preloadable by hierarchical reference to the array named `memory`, indexed by line.

## Timing
- Request accepted at edge T: ack_o is high during the cycle after edge T+LATENCY-1, i.e. exactly LATENCY cycles after accept.
- Write data is visible to a read accepted at or after the edge ending the ACK cycle.
- Requester protocol:
  - Hold enable_i high until it sees ack_o.
  - Drop enable_i by the edge ending the ACK cycle.
  - If enable_i is still high at the first IDLE edge, that is a new request.
- Minimum request-to-request spacing is LATENCY+1 cycles.
- Reset values: state IDLE, ack_o 0, busy_o 0, data_o 0, both counters 0, countdown 0.
- Reset asserted mid-request (WAIT or ACK): the request is aborted. No memory write, no ack, no counter update. Reset has priority over every other event.
- Reset and enable_i high on the same edge: the request is not accepted.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE/WAIT/ACK);
  - default LINE_W and DEPTH constants;
  - a clog2-based width function used for OFF_W and IDX_W.
- One sub-module, `mem_line_array`: a synchronous single-port line store with write enable and registered read. It is instantiated once and holds the preloadable `memory` array.
- Top level contains the FSM, countdown, request latches and counters.

## Test plan
- Preload mem[0] = 256'h0000_1111_…_FFFF; read addr 0x0000 at LATENCY=10 -> ack_o high exactly 10 cycles after accept, data_o = preload, rd_count_o = 1, busy_o high for 10 cycles.
- Write 256'hA5…A5 to 0x0220, then read 0x0220 -> read returns 256'hA5…A5, wr_count_o = 1, rd_count_o = 1, and line 17 holds the data.
- Read address 0x4020 with DEPTH=512 -> same line as 0x0020 (wrap): data_o = mem[1].
- Drop enable_i two cycles after accept of a write -> write still completes and ack_o still pulses at LATENCY.
- Assert rst_i in cycle 5 of a write -> no ack, line unchanged, counters 0. A new read issued after reset completes normally.
- LATENCY=1: ack_o in the cycle after accept. Back-to-back reads at the minimum 2-cycle spacing both complete. Counter preset to all-ones stays at all-ones after a read.
